alu_seq_responder: RTL and testbench

ALU_SEQ_RESPONDER -- requirements
Module: alu_seq_responder

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_rsp_fifo.sv | 73 +++++++
 rtl/alu_seq_responder.sv | 136 +++++++++++++
 tb/tb_alu_seq_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU responder: opcode encoding,
// ALU result record and the width of one queued response.
package alu_pkg;

    localparam int RES_W      = 4;
    localparam int FLAG_W     = 2;   // carry + zero
    localparam int RSP_BASE_W = RES_W + FLAG_W;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    typedef struct packed {
        logic [RES_W-1:0] result;
        logic             carry;
        logic             zero;
    } alu_res_t;

    // Width of one FIFO entry: {result, carry, zero, tag}.
    function automatic int rsp_width(input int tag_w);
        return RSP_BASE_W + tag_w;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Response queue for the ALU responder: DEPTH entries of DATA_W bits,
// first-word-fall-through read, occupancy exported as a level count.
module alu_rsp_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;

    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; stale entries are
    // unreachable because level/pointers are reset and the head is gated by level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    a_level_bound: assert property (
        @(posedge clk) disable iff (!rst_n) r_level <= FULL_LVL
    );

endmodule

// File: rtl/alu_seq_responder.sv
// 4-bit ALU behind a valid/ready command port; each accepted command's
// {result, carry, zero, tag} is queued and returned in acceptance order.
module alu_seq_responder
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [RES_W-1:0]        cmd_a,
    input  logic [RES_W-1:0]        cmd_b,
    input  logic [2:0]              cmd_sel,
    input  logic [TAG_W-1:0]        cmd_tag,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [RES_W-1:0]        rsp_result,
    output logic                    rsp_carry,
    output logic                    rsp_zero,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int RSP_W = rsp_width(TAG_W);

    typedef struct packed {
        alu_res_t         res;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    logic             r_run;
    logic [RES_W:0]   w_sum;
    logic [RES_W:0]   w_diff;
    alu_res_t         w_alu;
    rsp_t             w_rsp_in;
    rsp_t             w_head;
    logic [RSP_W-1:0] w_head_bits;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Holds cmd_ready low through reset and raises it on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_sum  = {1'b0, cmd_a} + {1'b0, cmd_b};
    assign w_diff = {1'b0, cmd_a} - {1'b0, cmd_b};

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_alu.result = '0;
        w_alu.carry  = 1'b0;
        case (op_e'(cmd_sel))
            OP_ADD: begin
                w_alu.result = w_sum[RES_W-1:0];
                w_alu.carry  = w_sum[RES_W];
            end
            OP_SUB: begin
                w_alu.result = w_diff[RES_W-1:0];
                w_alu.carry  = w_diff[RES_W];   // borrow: set exactly when a < b
            end
            OP_AND: w_alu.result = cmd_a & cmd_b;
            OP_OR:  w_alu.result = cmd_a | cmd_b;
            OP_XOR: w_alu.result = cmd_a ^ cmd_b;
            OP_NOT: w_alu.result = ~cmd_a;
            OP_SHL: begin
                w_alu.result = {cmd_a[RES_W-2:0], 1'b0};
                w_alu.carry  = cmd_a[RES_W-1];
            end
            OP_SHR: begin
                w_alu.result = {1'b0, cmd_a[RES_W-1:1]};
                w_alu.carry  = cmd_a[0];
            end
        endcase
        w_alu.zero = (w_alu.result == '0);
    end

    assign w_rsp_in.res = w_alu;
    assign w_rsp_in.tag = cmd_tag;

    assign cmd_ready = r_run && !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = rsp_valid && rsp_ready;

    alu_rsp_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (RSP_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_rsp_in),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign w_head = w_head_bits;

    // Response fields read as zero whenever no response is queued.
    always_comb begin
        rsp_valid  = !w_empty;
        rsp_result = '0;
        rsp_carry  = 1'b0;
        rsp_zero   = 1'b0;
        rsp_tag    = '0;
        if (rsp_valid) begin
            rsp_result = w_head.res.result;
            rsp_carry  = w_head.res.carry;
            rsp_zero   = w_head.res.zero;
            rsp_tag    = w_head.tag;
        end
    end

    a_ready_means_room: assert property (
        @(posedge clk) disable iff (!rst_n) cmd_ready |-> !w_full
    );

    a_hold_when_stalled: assert property (
        @(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_result)
            && $stable(rsp_carry) && $stable(rsp_zero) && $stable(rsp_tag))
    );

endmodule

// File: tb/tb_alu_seq_responder.sv
// Randomized self-checking bench: a queue-based reference model predicts every
// output each cycle, plus directed scenarios with literal expected values.
module tb_alu_seq_responder;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [3:0]       result;
        logic             carry;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } exp_rsp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_a = '0;
    logic [3:0]       cmd_b = '0;
    logic [2:0]       cmd_sel = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [3:0]       rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic [TAG_W-1:0] rsp_tag;
    logic [LVL_W-1:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    exp_rsp_t exp_q[$];
    bit       run_m = 1'b0;

    alu_seq_responder #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .cmd_tag    (cmd_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .rsp_tag    (rsp_tag),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference ALU written from the opcode table with plain integer arithmetic.
    function automatic exp_rsp_t ref_op(input int a, input int b, input int sel, input int tag);
        int r;
        int c;
        exp_rsp_t o;
        r = 0;
        c = 0;
        case (sel)
            0: begin r = a + b; c = (r > 15) ? 1 : 0; r = r % 16; end
            1: begin c = (a < b) ? 1 : 0; r = (a - b + 16) % 16; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: begin r = (a * 2) % 16; c = (a >= 8) ? 1 : 0; end
            default: begin r = a / 2; c = a % 2; end
        endcase
        o.result = 4'(r);
        o.carry  = (c != 0);
        o.zero   = (r == 0);
        o.tag    = TAG_W'(tag);
        return o;
    endfunction

    task automatic compare_all();
        exp_rsp_t head;
        head = '0;
        if (exp_q.size() != 0) head = exp_q[0];
        check("cmd_ready", 32'(cmd_ready), 32'(run_m && exp_q.size() < DEPTH));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
        check("level", 32'(level), exp_q.size());
        check("rsp_result", 32'(rsp_result), 32'(head.result));
        check("rsp_carry", 32'(rsp_carry), 32'(head.carry));
        check("rsp_zero", 32'(rsp_zero), 32'(head.zero));
        check("rsp_tag", 32'(rsp_tag), 32'(head.tag));
    endtask

    // One clock cycle: drive after the falling edge, compare, then advance the model.
    task automatic tick(input bit v, input int a, input int b, input int sel,
                        input int tag, input bit rr);
        bit acc;
        bit pop;
        @(negedge clk);
        cmd_valid = v;
        cmd_a     = 4'(a);
        cmd_b     = 4'(b);
        cmd_sel   = 3'(sel);
        cmd_tag   = TAG_W'(tag);
        rsp_ready = rr;
        #1;
        compare_all();
        acc = v && run_m && (exp_q.size() < DEPTH);
        pop = rr && (exp_q.size() != 0);
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(ref_op(a, b, sel, tag));
        run_m = 1'b1;
    endtask

    task automatic expect_head(input string name, input int r, input int c,
                               input int z, input int t);
        #1;
        check({name, "_valid"}, 32'(rsp_valid), 1);
        check({name, "_result"}, 32'(rsp_result), r);
        check({name, "_carry"}, 32'(rsp_carry), c);
        check({name, "_zero"}, 32'(rsp_zero), z);
        check({name, "_tag"}, 32'(rsp_tag), t);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_level"}, 32'(level), 0);
        check({name, "_cmd_ready"}, 32'(cmd_ready), 0);
        check({name, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({name, "_result"}, 32'(rsp_result), 0);
        check({name, "_carry"}, 32'(rsp_carry), 0);
        check({name, "_zero"}, 32'(rsp_zero), 0);
        check({name, "_tag"}, 32'(rsp_tag), 0);
    endtask

    task automatic release_reset();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_state("rst_hold");
        rst_n = 1'b1;
        #1;
        check("cmd_ready_before_edge", 32'(cmd_ready), 0);
        @(posedge clk);
        #1;
        run_m = 1'b1;
        check("cmd_ready_after_edge", 32'(cmd_ready), 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        run_m = 1'b0;
        check_reset_state("rst_async");
        release_reset();
    endtask

    // Push one command into an empty queue, check it one cycle later, then drain it.
    task automatic one_shot(input string name, input int a, input int b, input int sel,
                            input int tag, input int r, input int c, input int z);
        tick(1'b1, a, b, sel, tag, 1'b0);
        expect_head(name, r, c, z, tag);
        tick(1'b0, 0, 0, 0, 0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check_reset_state("por");
        release_reset();

        one_shot("add_3_1", 3, 1, 0, 0, 4'b0100, 0, 0);
        one_shot("sub_4_1", 4, 1, 1, 1, 4'b0011, 0, 0);
        one_shot("sub_1_2", 1, 2, 1, 2, 4'b1111, 1, 0);
        one_shot("add_f_1", 15, 1, 0, 3, 4'b0000, 1, 1);

        tick(1'b1, 4'b1100, 4'b1010, 2, 1, 1'b1);
        expect_head("b2b_and", 4'b1000, 0, 0, 1);
        tick(1'b1, 4'b1100, 4'b1010, 3, 2, 1'b1);
        expect_head("b2b_or", 4'b1110, 0, 0, 2);
        tick(1'b1, 4'b1010, 4'b0000, 4, 3, 1'b1);
        expect_head("b2b_xor", 4'b1010, 0, 0, 3);
        tick(1'b0, 0, 0, 0, 0, 1'b1);
        #1;
        check("b2b_drained", 32'(rsp_valid), 0);

        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 7), i, 1'b0);
        end
        #1;
        check("full_cmd_ready", 32'(cmd_ready), 0);
        check("full_level", 32'(level), DEPTH);
        tick(1'b0, 0, 0, 0, 0, 1'b1);
        #1;
        check("after_pop_level", 32'(level), DEPTH - 1);
        check("after_pop_cmd_ready", 32'(cmd_ready), 1);

        tick(1'b1, 6, 7, 6, 1, 1'b0);
        #1;
        check("refill_level", 32'(level), DEPTH);
        tick(1'b1, 9, 2, 7, 2, 1'b1);
        #1;
        check("full_push_pop_level", 32'(level), DEPTH - 1);
        tick(1'b1, 5, 5, 1, 3, 1'b1);
        #1;
        check("push_pop_level", 32'(level), DEPTH - 1);

        pulse_reset();
        one_shot("post_rst_add", 5, 6, 0, 2, 4'b1011, 0, 0);

        for (int i = 0; i < 400; i++) begin
            int pv;
            int pr;
            pv = (i < 100) ? 80 : 55;
            pr = (i < 100) ? 25 : 60;
            if (i == 250) pulse_reset();
            tick($urandom_range(0, 99) < pv, $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 99) < pr);
        end

        tick(1'b0, 0, 0, 0, 0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
